sfp_serial_tx: RTL and testbench

Framed NRZ serializer that drives the SFP transmit line at i_clk / CLK_PER_BIT, as the transmitting end of the link whose far end is our oversampling CDR receiver. It accepts parallel words on a valid/ready handshake and emits each word as sync + data + parity. Between frames it sends a toggling idle pattern so the receiver always sees transitions and stays phase-locked. Every line transition is at least CLK_PER_BIT clocks from the previous one, so the CDR never flags a short-pulse error.

---
 rtl/sfp_serial_tx.sv | 147 ++++++++++++++
 tb/tb_sfp_serial_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_serial_tx.sv
// Framed NRZ serializer for the SFP TX line: sync run, MSB-first payload, even parity.
// Between frames the line toggles every bit so the far-end CDR stays locked.
module sfp_serial_tx #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CLK_PER_BIT = 4,
    parameter int unsigned SYNC_LEN    = 3,
    parameter int unsigned MIN_IDLE    = 2
) (
    input  logic              i_clk,
    input  logic              i_res,
    input  logic [DATA_W-1:0] i_Data,
    input  logic              i_Valid,
    output logic              o_Ready,
    output logic              o_SerialData,
    output logic              o_BitEn,
    output logic              o_Busy
);

    localparam int unsigned DIV_W   = $clog2(CLK_PER_BIT);
    localparam int unsigned CNT_MAX = (SYNC_LEN + 1 > DATA_W) ? SYNC_LEN + 1 : DATA_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDL_W   = $clog2(MIN_IDLE + 1);

    typedef enum logic [1:0] {StIdle, StSync, StData, StParity} state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDL_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                parity_q, parity_d;
    logic                pending_q, pending_d;
    logic                line_q, line_d;
    logic                bit_en_q, bit_en_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    logic bnd;
    logic accept;

    // bnd marks the last cycle of a bit period; the registered line changes on the next edge.
    assign bnd    = (div_q == DIV_W'(CLK_PER_BIT - 1));
    assign accept = i_Valid & ready_q;

    always_comb begin
        state_d    = state_q;
        div_d      = bnd ? '0 : div_q + DIV_W'(1);
        cnt_d      = cnt_q;
        idle_cnt_d = idle_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        pending_d  = pending_q;
        line_d     = line_q;
        bit_en_d   = bnd;

        if (accept) begin
            shift_d   = i_Data;
            parity_d  = ^i_Data;
            pending_d = 1'b1;
        end

        if (bnd) begin
            unique case (state_q)
                StIdle: begin
                    if (pending_q || accept) begin
                        state_d    = StSync;
                        cnt_d      = '0;
                        idle_cnt_d = '0;
                        pending_d  = 1'b0;
                        line_d     = 1'b1;
                    end else begin
                        line_d = ~line_q;
                        if (idle_cnt_q < IDL_W'(MIN_IDLE)) begin
                            idle_cnt_d = idle_cnt_q + IDL_W'(1);
                        end
                    end
                end
                StSync: begin
                    if (cnt_q == CNT_W'(SYNC_LEN)) begin
                        state_d = StData;
                        cnt_d   = '0;
                        line_d  = shift_q[DATA_W-1];
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                    end else begin
                        // Ones until the terminator slot, which drives the closing zero.
                        line_d = (cnt_q != CNT_W'(SYNC_LEN - 1));
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
                StData: begin
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = StParity;
                        line_d  = parity_q;
                    end else begin
                        line_d  = shift_q[DATA_W-1];
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                StParity: begin
                    // Idle count includes the idle bit currently on the line.
                    state_d    = StIdle;
                    line_d     = ~line_q;
                    idle_cnt_d = IDL_W'(1);
                end
                default: state_d = StIdle;
            endcase
        end

        ready_d = (state_d == StIdle) && !pending_d && (idle_cnt_d >= IDL_W'(MIN_IDLE));
        busy_d  = pending_d || (state_d != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state_q    <= StIdle;
            div_q      <= '0;
            cnt_q      <= '0;
            idle_cnt_q <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            pending_q  <= 1'b0;
            line_q     <= 1'b0;
            bit_en_q   <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            idle_cnt_q <= idle_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            pending_q  <= pending_d;
            line_q     <= line_d;
            bit_en_q   <= bit_en_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign o_Ready      = ready_q;
    assign o_SerialData = line_q;
    assign o_BitEn      = bit_en_q;
    assign o_Busy       = busy_q;

endmodule

// File: tb/tb_sfp_serial_tx.sv
// Directed bench for sfp_serial_tx with an inline 4x-oversampling receiver model.
module tb_sfp_serial_tx;

    localparam int CPB = 4;

    logic       i_clk = 1'b0;
    logic       i_res = 1'b1;
    logic       i_Valid = 1'b0;
    logic [7:0] i_Data = 8'h00;
    logic       o_Ready, o_SerialData, o_BitEn, o_Busy;

    always #5 i_clk = ~i_clk;

    sfp_serial_tx dut (
        .i_clk       (i_clk),
        .i_res       (i_res),
        .i_Data      (i_Data),
        .i_Valid     (i_Valid),
        .o_Ready     (o_Ready),
        .o_SerialData(o_SerialData),
        .o_BitEn     (o_BitEn),
        .o_Busy      (o_Busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Receiver model state: phase recovered from line transitions, sampled mid-bit.
    bit         rx_en = 1'b0;
    logic       rx_prev = 1'b0;
    bit         rx_seen = 1'b0;
    int         rx_run = 0, rx_ph = 0, rx_short = 0;
    int         rx_st = 0, rx_ones = 0, rx_nb = 0;
    logic [7:0] rx_word = 8'h00;
    logic [7:0] rx_q[$];
    bit         rx_pok[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rx_bit(input logic b);
        case (rx_st)
            0: begin
                if (b) rx_ones++;
                else begin
                    if (rx_ones >= 3) begin
                        rx_st = 1; rx_nb = 0; rx_word = 8'h00;
                    end
                    rx_ones = 0;
                end
            end
            1: begin
                rx_word = {rx_word[6:0], b};
                rx_nb++;
                if (rx_nb == 8) rx_st = 2;
            end
            default: begin
                rx_q.push_back(rx_word);
                rx_pok.push_back((^rx_word) == b);
                rx_st = 0; rx_ones = 0;
            end
        endcase
    endtask

    task automatic rx_step();
        if (!rx_en) begin
            rx_seen = 1'b0; rx_run = 0; rx_ph = 0; rx_st = 0; rx_ones = 0; rx_nb = 0;
        end else begin
            if (o_SerialData !== rx_prev) begin
                if (rx_seen && rx_run < CPB) rx_short++;
                rx_seen = 1'b1; rx_run = 1; rx_ph = 0;
            end else begin
                rx_run++; rx_ph++;
            end
            if (rx_ph % CPB == 2) rx_bit(o_SerialData);
        end
        rx_prev = o_SerialData;
    endtask

    task automatic tick();
        @(negedge i_clk);
        rx_step();
    endtask

    // Entered at the negedge after the last reset edge, with i_res still high.
    task automatic reset_then_idle(input string tag);
        logic exp_line;
        check({tag, "_rst_line"}, o_SerialData, 0);
        check({tag, "_rst_ready"}, o_Ready, 0);
        check({tag, "_rst_biten"}, o_BitEn, 0);
        check({tag, "_rst_busy"}, o_Busy, 0);
        i_res = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_line = (k >= 4) && (((k / 4) % 2) == 1);
            check({tag, "_idle_line"}, o_SerialData, exp_line);
            check({tag, "_idle_biten"}, o_BitEn, (k % 4) == 0);
            check({tag, "_idle_ready"}, o_Ready, k >= 8);
            check({tag, "_idle_busy"}, o_Busy, 0);
        end
        rx_en = 1'b1;
    endtask

    task automatic send(input logic [7:0] d);
        int w = 0;
        int lat = 1;
        while (!o_Ready && w < 200) begin
            tick(); w++;
        end
        check("ready_wait", o_Ready, 1);
        i_Valid = 1'b1; i_Data = d;
        tick();
        i_Valid = 1'b0; i_Data = ~d;
        check("ready_drop", o_Ready, 0);
        check("busy_rise", o_Busy, 1);
        while (!o_BitEn && lat < CPB) begin
            tick(); lat++;
        end
        check("start_lat", o_BitEn, 1);
    endtask

    // Captures 13 frame bits plus the first idle bit, checking bit timing and busy.
    task automatic frame_test(input string tag, input logic [7:0] d, input logic [13:0] exp);
        logic [13:0] bits;
        int bad_busy = 0;
        int bad_time = 0;
        send(d);
        for (int j = 0; j < 14; j++) begin
            bits[13-j] = o_SerialData;
            if (o_Busy !== (j < 13)) bad_busy++;
            for (int c = 1; c < CPB; c++) begin
                tick();
                if (o_SerialData !== bits[13-j] || o_BitEn !== 1'b0) bad_time++;
            end
            tick();
            if (o_BitEn !== 1'b1) bad_time++;
        end
        check({tag, "_bits"}, bits, exp);
        check({tag, "_busy"}, bad_busy, 0);
        check({tag, "_timing"}, bad_time, 0);
    endtask

    logic [7:0] words[100];
    int         acc_t[5];

    initial begin
        int base, n_acc, cyc;
        bit acc_now;

        // 1: reset and idle pattern
        repeat (3) tick();
        reset_then_idle("t1");

        // 2-3: single frames
        frame_test("a5", 8'hA5, 14'b1110_10100101_0_1);
        frame_test("00", 8'h00, 14'b1110_00000000_0_1);
        frame_test("ff", 8'hFF, 14'b1110_11111111_0_1);
        frame_test("01", 8'h01, 14'b1110_00000001_1_0);

        // 4: back-to-back with i_Valid held
        base = rx_q.size();
        n_acc = 0; cyc = 0;
        i_Data = 8'h10; i_Valid = 1'b1;
        while (n_acc < 5 && cyc < 600) begin
            acc_now = o_Ready;
            if (acc_now) begin
                acc_t[n_acc] = cyc; n_acc++;
            end
            tick(); cyc++;
            if (acc_now) i_Data = i_Data + 8'h01;
        end
        i_Valid = 1'b0;
        check("b2b_count", n_acc, 5);
        for (int i = 0; i < 4; i++) check("b2b_interval", acc_t[i+1] - acc_t[i], 60);
        repeat (80) tick();
        check("b2b_rx_count", rx_q.size() - base, 5);
        for (int i = 0; i < 5; i++) begin
            check("b2b_word", (base + i < rx_q.size()) ? rx_q[base+i] : 8'hxx, 8'h10 + i);
            check("b2b_parity", (base + i < rx_pok.size()) ? rx_pok[base+i] : 1'b0, 1);
        end
        check("b2b_short", rx_short, 0);

        // 5: reset during the 5th data bit of 0xC3
        send(8'hC3);
        repeat (8 * CPB) tick();
        tick();
        check("t5_busy_pre", o_Busy, 1);
        check("t5_data4", o_SerialData, 0);
        i_res = 1'b1; rx_en = 1'b0;
        tick();
        reset_then_idle("t5");

        // 6: 100 random words through the receiver model
        for (int i = 0; i < 100; i++) words[i] = 8'($urandom);
        base = rx_q.size();
        n_acc = 0; cyc = 0;
        i_Data = words[0]; i_Valid = 1'b1;
        while (n_acc < 100 && cyc < 8000) begin
            acc_now = o_Ready;
            if (acc_now) n_acc++;
            tick(); cyc++;
            if (acc_now && n_acc < 100) i_Data = words[n_acc];
        end
        i_Valid = 1'b0;
        repeat (80) tick();
        check("cdr_accepts", n_acc, 100);
        check("cdr_rx_count", rx_q.size() - base, 100);
        for (int i = 0; i < 100; i++) begin
            check("cdr_word", (base + i < rx_q.size()) ? rx_q[base+i] : 8'hxx, words[i]);
            check("cdr_parity", (base + i < rx_pok.size()) ? rx_pok[base+i] : 1'b0, 1);
        end
        check("cdr_short", rx_short, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
